// File: rtl/afe_ctrl_seq_pkg.sv
// rtl/afe_ctrl_seq_pkg.sv - state encoding and config field helpers for the AFE sequencer
package afe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BG_WAIT = 3'd1,
        ST_CH_ON   = 3'd2,
        ST_ACTIVE  = 3'd3,
        ST_FAULT   = 3'd4
    } afe_state_e;

    function automatic int cfg_w(input int n_ch, input int trim_w);
        return n_ch * (1 + trim_w);
    endfunction

    // Channel field is {en, trim}; en sits just above the trim bits.
    function automatic int trim_pos(input int ch, input int trim_w);
        return ch * (1 + trim_w);
    endfunction

    function automatic int en_pos(input int ch, input int trim_w);
        return ch * (1 + trim_w) + trim_w;
    endfunction

endpackage

// File: rtl/afe_ctrl_seq_if.sv
// rtl/afe_ctrl_seq_if.sv - control/status bundle between pin logic and the AFE sequencer
interface afe_ctrl_seq_if #(
    parameter int N_CH   = 3,
    parameter int TRIM_W = 4
);
    logic                     cfg_sdi;
    logic                     cfg_shift;
    logic                     cfg_latch;
    logic                     start;
    logic                     stop;
    logic                     bg_ok;
    logic                     bg_en;
    logic [N_CH-1:0]          ch_en;
    logic [N_CH*TRIM_W-1:0]   ch_trim;
    logic                     ready;
    logic                     fault;
    logic [2:0]               state_o;

    modport master (
        output cfg_sdi, cfg_shift, cfg_latch, start, stop, bg_ok,
        input  bg_en, ch_en, ch_trim, ready, fault, state_o
    );

    modport slave (
        input  cfg_sdi, cfg_shift, cfg_latch, start, stop, bg_ok,
        output bg_en, ch_en, ch_trim, ready, fault, state_o
    );
endinterface

// File: rtl/afe_ctrl_seq_sync_2ff.sv
// rtl/afe_ctrl_seq_sync_2ff.sv - two-flop synchronizer for asynchronous analog status inputs
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/afe_ctrl_seq.sv
// rtl/afe_ctrl_seq.sv - bandgap/channel power-up sequencer with serial trim configuration
module afe_ctrl_seq
    import afe_ctrl_pkg::*;
#(
    parameter int N_CH       = 3,
    parameter int TRIM_W     = 4,
    parameter int SETTLE_CYC = 200,
    parameter int STEP_CYC   = 16,
    parameter int CNT_W      = 8
) (
    input  logic           clk,
    input  logic           rst,
    afe_ctrl_seq_if.slave  bus
);
    localparam int CFG_W = cfg_w(N_CH, TRIM_W);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    afe_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CFG_W-1:0]       shadow_q;
    logic [CFG_W-1:0]       active_q;
    logic [CFG_W-1:0]       active_d;
    logic                   pending_q;
    logic                   bg_en_q;
    logic                   ready_q;
    logic                   fault_q;
    logic [N_CH-1:0]        ch_en_q;
    logic                   bg_ok_s;

    logic [N_CH-1:0]        act_en;
    logic [N_CH-1:0]        nxt_en;
    logic [N_CH*TRIM_W-1:0] act_trim;
    logic                   step_done;
    logic                   last_ch;
    logic                   enter_active;
    logic                   latch_direct;

    sync_2ff #(.W(1)) u_bg_ok_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.bg_ok),
        .q_o (bg_ok_s)
    );

    assign step_done    = (cnt_q == CNT_W'(STEP_CYC - 1));
    assign last_ch      = (idx_q == IDX_W'(N_CH - 1));
    assign enter_active = (state_q == ST_CH_ON) && !bus.stop && bg_ok_s && step_done && last_ch;
    assign latch_direct = bus.cfg_latch &&
                          ((state_q == ST_IDLE) || (state_q == ST_ACTIVE) || (state_q == ST_FAULT));

    // A latch during sequencing is deferred so trims never move mid power-up.
    always_comb begin
        active_d = active_q;
        if (latch_direct || (enter_active && (pending_q || bus.cfg_latch))) begin
            active_d = shadow_q;
        end
    end

    always_comb begin
        act_en   = '0;
        nxt_en   = '0;
        act_trim = '0;
        for (int i = 0; i < N_CH; i++) begin
            act_en[i]                     = active_q[en_pos(i, TRIM_W)];
            nxt_en[i]                     = active_d[en_pos(i, TRIM_W)];
            act_trim[i*TRIM_W +: TRIM_W]  = active_q[trim_pos(i, TRIM_W) +: TRIM_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            bg_en_q   <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            ch_en_q   <= '0;
        end else begin
            if (bus.cfg_shift) begin
                shadow_q <= {shadow_q[CFG_W-2:0], bus.cfg_sdi};
            end
            active_q <= active_d;

            if (bus.stop && (state_q != ST_IDLE)) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                idx_q     <= '0;
                pending_q <= 1'b0;
                bg_en_q   <= 1'b0;
                ready_q   <= 1'b0;
                fault_q   <= 1'b0;
                ch_en_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start && !bus.stop) begin
                            state_q <= ST_BG_WAIT;
                            bg_en_q <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                    ST_BG_WAIT: begin
                        if (bus.cfg_latch) pending_q <= 1'b1;
                        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                            cnt_q <= '0;
                            if (bg_ok_s) begin
                                state_q <= ST_CH_ON;
                                idx_q   <= '0;
                            end else begin
                                state_q <= ST_FAULT;
                                bg_en_q <= 1'b0;
                                fault_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_CH_ON: begin
                        if (!bg_ok_s) begin
                            state_q <= ST_FAULT;
                            bg_en_q <= 1'b0;
                            ch_en_q <= '0;
                            fault_q <= 1'b1;
                        end else begin
                            if (bus.cfg_latch) pending_q <= 1'b1;
                            if (step_done) begin
                                cnt_q          <= '0;
                                ch_en_q[idx_q] <= act_en[idx_q];
                                if (last_ch) begin
                                    state_q   <= ST_ACTIVE;
                                    ready_q   <= 1'b1;
                                    ch_en_q   <= nxt_en;
                                    pending_q <= 1'b0;
                                end else begin
                                    idx_q <= idx_q + IDX_W'(1);
                                end
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_ACTIVE: begin
                        if (!bg_ok_s) begin
                            state_q <= ST_FAULT;
                            bg_en_q <= 1'b0;
                            ch_en_q <= '0;
                            ready_q <= 1'b0;
                            fault_q <= 1'b1;
                        end else begin
                            ch_en_q <= nxt_en;
                        end
                    end
                    ST_FAULT: begin
                        fault_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        bg_en_q <= 1'b0;
                        ch_en_q <= '0;
                        ready_q <= 1'b0;
                        fault_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.bg_en   = bg_en_q;
    assign bus.ch_en   = ch_en_q;
    assign bus.ch_trim = act_trim;
    assign bus.ready   = ready_q;
    assign bus.fault   = fault_q;
    assign bus.state_o = state_q;
endmodule

// File: tb/tb_afe_ctrl_seq.sv
// tb/tb_afe_ctrl_seq.sv - directed self-checking bench for afe_ctrl_seq
module tb_afe_ctrl_seq;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    afe_ctrl_seq_if #(.N_CH(3), .TRIM_W(4)) bus ();

    afe_ctrl_seq #(
        .N_CH(3), .TRIM_W(4), .SETTLE_CYC(8), .STEP_CYC(4), .CNT_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_cfg(input logic [14:0] v);
        for (int i = 14; i >= 0; i--) begin
            bus.cfg_sdi   = v[i];
            bus.cfg_shift = 1'b1;
            tick(1);
        end
        bus.cfg_shift = 1'b0;
        bus.cfg_sdi   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
    endtask

    task automatic pulse_latch();
        bus.cfg_latch = 1'b1;
        tick(1);
        bus.cfg_latch = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        bus.cfg_sdi = 1'b0; bus.cfg_shift = 1'b0; bus.cfg_latch = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.bg_ok = 1'b1;
        tick(3);
        rst = 1'b0;

        // 1: reset state, then shift and latch in IDLE
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_bg_en", 32'(bus.bg_en), 32'd0);
        check("rst_ch_en", 32'(bus.ch_en), 32'd0);
        check("rst_trim", 32'(bus.ch_trim), 32'h000);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        shift_cfg(15'b11010_00101_10011);
        check("trim_before_latch", 32'(bus.ch_trim), 32'h000);
        pulse_latch();
        check("trim_latched", 32'(bus.ch_trim), 32'hA53);
        check("ch_en_idle", 32'(bus.ch_en), 32'd0);

        // 2: power-up sequence with ch1 disabled
        pulse_start();
        check("seq_bg_en", 32'(bus.bg_en), 32'd1);
        check("seq_bg_wait", 32'(bus.state_o), 32'd1);
        tick(11);
        check("seq_ch_en_e11", 32'(bus.ch_en), 32'd0);
        tick(1);
        check("seq_ch0", 32'(bus.ch_en), 32'b001);
        check("seq_ch_on", 32'(bus.state_o), 32'd2);
        tick(4);
        check("seq_ch1_off", 32'(bus.ch_en), 32'b001);
        tick(3);
        check("seq_pre_active", 32'(bus.state_o), 32'd2);
        check("seq_pre_ready", 32'(bus.ready), 32'd0);
        tick(1);
        check("seq_ch2", 32'(bus.ch_en), 32'b101);
        check("seq_active", 32'(bus.state_o), 32'd3);
        check("seq_ready", 32'(bus.ready), 32'd1);

        // latch in ACTIVE updates trims and enables directly
        shift_cfg(15'b01111_10000_11001);
        check("act_trim_hold", 32'(bus.ch_trim), 32'hA53);
        pulse_latch();
        check("act_trim_new", 32'(bus.ch_trim), 32'hF09);
        check("act_en_new", 32'(bus.ch_en), 32'b011);

        // 4: bandgap drop in ACTIVE
        bus.bg_ok = 1'b0;
        tick(2);
        check("drop_sync_lat", 32'(bus.state_o), 32'd3);
        tick(1);
        check("drop_fault_st", 32'(bus.state_o), 32'd4);
        check("drop_fault", 32'(bus.fault), 32'd1);
        check("drop_ch_en", 32'(bus.ch_en), 32'd0);
        check("drop_bg_en", 32'(bus.bg_en), 32'd0);
        check("drop_ready", 32'(bus.ready), 32'd0);
        bus.start = 1'b1;
        tick(2);
        bus.start = 1'b0;
        check("fault_ign_start", 32'(bus.state_o), 32'd4);
        pulse_stop();
        check("fault_stop_st", 32'(bus.state_o), 32'd0);
        check("fault_stop_flt", 32'(bus.fault), 32'd0);

        // 3: bandgap never OK
        pulse_start();
        tick(7);
        check("nobg_wait", 32'(bus.state_o), 32'd1);
        check("nobg_bg_en", 32'(bus.bg_en), 32'd1);
        tick(1);
        check("nobg_fault_st", 32'(bus.state_o), 32'd4);
        check("nobg_fault", 32'(bus.fault), 32'd1);
        check("nobg_bg_off", 32'(bus.bg_en), 32'd0);
        pulse_stop();
        check("nobg_idle", 32'(bus.state_o), 32'd0);
        check("nobg_fault_clr", 32'(bus.fault), 32'd0);

        // 5: latch during sequencing is deferred to ACTIVE entry
        bus.bg_ok = 1'b1;
        tick(3);
        pulse_start();
        shift_cfg(15'b10001_10010_00100);
        pulse_latch();
        check("defer_state", 32'(bus.state_o), 32'd2);
        check("defer_trim", 32'(bus.ch_trim), 32'hF09);
        check("defer_ch_en", 32'(bus.ch_en), 32'b011);
        tick(3);
        check("defer_trim_e19", 32'(bus.ch_trim), 32'hF09);
        tick(1);
        check("defer_active", 32'(bus.state_o), 32'd3);
        check("defer_trim_new", 32'(bus.ch_trim), 32'h124);
        check("defer_en_new", 32'(bus.ch_en), 32'b110);

        // 6: stop and rst mid-CH_ON
        pulse_stop();
        check("stop_act_idle", 32'(bus.state_o), 32'd0);
        check("stop_act_en", 32'(bus.ch_en), 32'd0);
        pulse_start();
        tick(16);
        check("mid_ch_en", 32'(bus.ch_en), 32'b010);
        pulse_stop();
        check("mid_stop_st", 32'(bus.state_o), 32'd0);
        check("mid_stop_en", 32'(bus.ch_en), 32'd0);
        check("mid_stop_bg", 32'(bus.bg_en), 32'd0);
        pulse_start();
        tick(16);
        check("mid2_ch_en", 32'(bus.ch_en), 32'b010);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_st", 32'(bus.state_o), 32'd0);
        check("mid_rst_en", 32'(bus.ch_en), 32'd0);
        check("mid_rst_bg", 32'(bus.bg_en), 32'd0);
        check("mid_rst_trim", 32'(bus.ch_trim), 32'h000);

        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("start_stop_st", 32'(bus.state_o), 32'd0);
        check("start_stop_bg", 32'(bus.bg_en), 32'd0);

        // latch and shift in the same cycle captures the pre-shift shadow
        shift_cfg(15'b11010_00101_10011);
        bus.cfg_sdi   = 1'b1;
        bus.cfg_shift = 1'b1;
        bus.cfg_latch = 1'b1;
        tick(1);
        bus.cfg_sdi   = 1'b0;
        bus.cfg_shift = 1'b0;
        bus.cfg_latch = 1'b0;
        check("ls_pre_shift", 32'(bus.ch_trim), 32'hA53);
        pulse_latch();
        check("ls_post_shift", 32'(bus.ch_trim), 32'h4B7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
